// File: rtl/lookup_mt.sv
// Exact-match lookup table with a 3-stage stall-able request pipeline and a
// localbus slave for table, hit-counter and default-action access.
module lookup_mt #(
   parameter int unsigned KEY_W = 64,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned ACT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             p2k_valid,
   output logic             p2k_ready,
   input  logic [7:0]       p2k_ingress,
   input  logic [127:0]     p2k_rloc_src,
   input  logic [127:0]     p2k_eid_dst,
   input  logic             mode,
   output logic             action_valid,
   input  logic             action_ready,
   output logic [ACT_W-1:0] action,
   output logic             action_hit,
   output logic [7:0]       action_index,
   input  logic             localbus_cs_n,
   input  logic             localbus_rd_wr,
   input  logic [31:0]      localbus_data,
   input  logic             localbus_ale,
   output logic             localbus_ack_n,
   output logic [31:0]      localbus_data_out
);

   localparam int unsigned KW = (KEY_W + 31) / 32;

   typedef enum logic [1:0] {StIdle, StExec, StAck, StWait} bus_st_e;

   // Table storage
   logic             tbl_valid_q [DEPTH];
   logic [KEY_W-1:0] tbl_key_q   [DEPTH];
   logic [ACT_W-1:0] tbl_act_q   [DEPTH];
   logic [31:0]      tbl_cnt_q   [DEPTH];
   logic [ACT_W-1:0] def_act_q;

   // Pipeline registers
   logic             en;
   logic [KEY_W-1:0] key_in;
   logic             s1_valid_q;
   logic [KEY_W-1:0] s1_key_q;
   logic             cmp_hit;
   logic [7:0]       cmp_idx;
   logic [ACT_W-1:0] cmp_act;
   logic             s2_valid_q;
   logic             s2_hit_q;
   logic [7:0]       s2_idx_q;
   logic [ACT_W-1:0] s2_act_q;
   logic             action_valid_q;
   logic             action_hit_q;
   logic [7:0]       action_index_q;
   logic [ACT_W-1:0] action_q;
   logic             xfer;

   // Localbus
   bus_st_e          st_q;
   logic [31:0]      addr_q;
   logic             ack_n_q;
   logic [31:0]      data_out_q;
   logic [7:0]       acc_idx;
   logic [3:0]       acc_word;
   logic             is_def;
   logic             is_ent;
   logic             exec_wr;
   logic [KEY_W-1:0] sel_key;
   logic [KW*32-1:0] key_pad;
   logic [KW*32-1:0] wr_pad;
   logic [KEY_W-1:0] wr_key;
   logic [31:0]      rd_data;

   // The whole pipeline advances unless a presented result is being refused.
   assign en        = !(action_valid_q && !action_ready);
   assign p2k_ready = en;
   assign xfer      = action_valid_q && action_ready;

   // Key selection; the EID is zero-extended so keys wider than 128 bits stay defined.
   always_comb begin
      logic [135:0] sel_src;
      sel_src = mode ? {p2k_ingress, p2k_rloc_src} : {8'd0, p2k_eid_dst};
      key_in  = sel_src[KEY_W-1:0];
   end

   // S1: key register
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s1_key_q   <= '0;
      end else if (en) begin
         s1_valid_q <= p2k_valid;
         s1_key_q   <= key_in;
      end
   end

   // Parallel compare; scanning downwards leaves the lowest matching index.
   always_comb begin
      cmp_hit = 1'b0;
      cmp_idx = '0;
      cmp_act = def_act_q;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (tbl_valid_q[i] && (tbl_key_q[i] == s1_key_q)) begin
            cmp_hit = 1'b1;
            cmp_idx = 8'(i);
            cmp_act = tbl_act_q[i];
         end
      end
   end

   // S2: compare result register
   always_ff @(posedge clk) begin
      if (!reset) begin
         s2_valid_q <= 1'b0;
         s2_hit_q   <= 1'b0;
         s2_idx_q   <= '0;
         s2_act_q   <= '0;
      end else if (en) begin
         s2_valid_q <= s1_valid_q;
         s2_hit_q   <= cmp_hit;
         s2_idx_q   <= cmp_idx;
         s2_act_q   <= cmp_act;
      end
   end

   // S3: output register, held while the consumer stalls
   always_ff @(posedge clk) begin
      if (!reset) begin
         action_valid_q <= 1'b0;
         action_hit_q   <= 1'b0;
         action_index_q <= '0;
         action_q       <= '0;
      end else if (en) begin
         action_valid_q <= s2_valid_q;
         action_hit_q   <= s2_hit_q;
         action_index_q <= s2_idx_q;
         action_q       <= s2_act_q;
      end
   end

   assign action_valid = action_valid_q;
   assign action_hit   = action_hit_q;
   assign action_index = action_index_q;
   assign action       = action_q;

   // Address latch, independent of the access FSM
   always_ff @(posedge clk) begin
      if (!reset) begin
         addr_q <= '0;
      end else if (localbus_ale) begin
         addr_q <= localbus_data;
      end
   end

   // Address decode and read-data / write-key construction
   always_comb begin
      acc_idx  = addr_q[15:8];
      acc_word = addr_q[3:0];
      is_def   = (addr_q == 32'h0000_FFFF);
      is_ent   = (addr_q[31:16] == 16'd0) && (addr_q[7:4] == 4'd0) &&
                 ({1'b0, acc_idx} < 9'(DEPTH));
      exec_wr  = (st_q == StExec) && !localbus_rd_wr;

      sel_key = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (acc_idx == 8'(i)) sel_key = tbl_key_q[i];
      end
      key_pad              = '0;
      key_pad[KEY_W-1:0]   = sel_key;
      wr_pad               = key_pad;
      for (int w = 0; w < KW; w++) begin
         if (acc_word == 4'(w)) wr_pad[32*w +: 32] = localbus_data;
      end
      wr_key = wr_pad[KEY_W-1:0];

      rd_data = '0;
      if (is_def) begin
         rd_data[ACT_W-1:0] = def_act_q;
      end else if (is_ent) begin
         for (int w = 0; w < KW; w++) begin
            if (acc_word == 4'(w)) rd_data = key_pad[32*w +: 32];
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (acc_idx == 8'(i)) begin
               if (acc_word == 4'd8) begin
                  rd_data[31]        = tbl_valid_q[i];
                  rd_data[ACT_W-1:0] = tbl_act_q[i];
               end else if (acc_word == 4'd9) begin
                  rd_data = tbl_cnt_q[i];
               end
            end
         end
      end
   end

   // Table, default action and hit counters; a counter clear beats an increment.
   always_ff @(posedge clk) begin
      if (!reset) begin
         def_act_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tbl_valid_q[i] <= 1'b0;
            tbl_key_q[i]   <= '0;
            tbl_act_q[i]   <= '0;
            tbl_cnt_q[i]   <= '0;
         end
      end else begin
         if (exec_wr && is_def) def_act_q <= localbus_data[ACT_W-1:0];
         for (int i = 0; i < DEPTH; i++) begin
            if (exec_wr && is_ent && (acc_idx == 8'(i)) && (acc_word < 4'(KW))) begin
               tbl_key_q[i] <= wr_key;
            end
            if (exec_wr && is_ent && (acc_idx == 8'(i)) && (acc_word == 4'd8)) begin
               tbl_valid_q[i] <= localbus_data[31];
               tbl_act_q[i]   <= localbus_data[ACT_W-1:0];
            end
            if (exec_wr && is_ent && (acc_idx == 8'(i)) && (acc_word == 4'd9)) begin
               tbl_cnt_q[i] <= '0;
            end else if (xfer && action_hit_q && (action_index_q == 8'(i)) &&
                         (tbl_cnt_q[i] != 32'hFFFF_FFFF)) begin
               tbl_cnt_q[i] <= tbl_cnt_q[i] + 32'd1;
            end
         end
      end
   end

   // Bus access FSM with registered acknowledge and read data
   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q       <= StIdle;
         ack_n_q    <= 1'b1;
         data_out_q <= '0;
      end else begin
         unique case (st_q)
            StIdle: begin
               if (!localbus_cs_n && !localbus_ale) st_q <= StExec;
            end
            StExec: begin
               st_q    <= StAck;
               ack_n_q <= 1'b0;
               if (localbus_rd_wr) data_out_q <= rd_data;
            end
            StAck: begin
               st_q    <= StWait;
               ack_n_q <= 1'b1;
            end
            StWait: begin
               if (localbus_cs_n) st_q <= StIdle;
            end
            default: st_q <= StIdle;
         endcase
      end
   end

   assign localbus_ack_n    = ack_n_q;
   assign localbus_data_out = data_out_q;

endmodule

// File: tb/tb_lookup_mt.sv
// Self-checking bench for lookup_mt: directed scenarios plus a randomized
// lookup stream scored against a queue-based reference model of the table.
module tb_lookup_mt;

   localparam int KEY_W = 64;
   localparam int DEPTH = 16;
   localparam int ACT_W = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              p2k_valid;
   logic              p2k_ready;
   logic [7:0]        p2k_ingress;
   logic [127:0]      p2k_rloc_src;
   logic [127:0]      p2k_eid_dst;
   logic              mode;
   logic              action_valid;
   logic              action_ready;
   logic [ACT_W-1:0]  action;
   logic              action_hit;
   logic [7:0]        action_index;
   logic              localbus_cs_n;
   logic              localbus_rd_wr;
   logic [31:0]       localbus_data;
   logic              localbus_ale;
   logic              localbus_ack_n;
   logic [31:0]       localbus_data_out;

   always #5 clk = ~clk;

   lookup_mt #(.KEY_W(KEY_W), .DEPTH(DEPTH), .ACT_W(ACT_W)) dut (
      .clk               (clk),
      .reset             (reset),
      .p2k_valid         (p2k_valid),
      .p2k_ready         (p2k_ready),
      .p2k_ingress       (p2k_ingress),
      .p2k_rloc_src      (p2k_rloc_src),
      .p2k_eid_dst       (p2k_eid_dst),
      .mode              (mode),
      .action_valid      (action_valid),
      .action_ready      (action_ready),
      .action            (action),
      .action_hit        (action_hit),
      .action_index      (action_index),
      .localbus_cs_n     (localbus_cs_n),
      .localbus_rd_wr    (localbus_rd_wr),
      .localbus_data     (localbus_data),
      .localbus_ale      (localbus_ale),
      .localbus_ack_n    (localbus_ack_n),
      .localbus_data_out (localbus_data_out)
   );

   typedef struct packed {
      logic        hit;
      logic [7:0]  idx;
      logic [15:0] act;
   } res_t;

   // Reference model state
   logic [63:0] m_key   [DEPTH];
   logic        m_valid [DEPTH];
   logic [15:0] m_act   [DEPTH];
   logic [31:0] m_cnt   [DEPTH];
   logic [15:0] m_def;
   res_t        exp_q[$];
   int          acc_cyc_q[$];

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   bit          accepted;
   int          xfers;
   int          last_lat;
   res_t        last_res;
   bit          prev_stall;
   res_t        prev_res;
   int          ready_low;
   logic [31:0] rd;
   logic [63:0] pool [6];
   logic [63:0] k21  [4];
   int          sent;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic res_t model_lookup(input logic [63:0] k);
      res_t r;
      r.hit = 1'b0;
      r.idx = 8'd0;
      r.act = m_def;
      for (int i = 0; i < DEPTH; i++) begin
         if (!r.hit && m_valid[i] && (m_key[i] == k)) begin
            r.hit = 1'b1;
            r.idx = 8'(i);
            r.act = m_act[i];
         end
      end
      return r;
   endfunction

   function automatic logic [63:0] model_key();
      logic [135:0] s;
      s = mode ? {p2k_ingress, p2k_rloc_src} : {8'h00, p2k_eid_dst};
      return s[63:0];
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_key[i]   = '0;
         m_valid[i] = 1'b0;
         m_act[i]   = '0;
         m_cnt[i]   = '0;
      end
      m_def = '0;
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [31:0] wd);
      int idx;
      int w;
      idx = int'(addr[15:8]);
      w   = int'(addr[3:0]);
      if (addr == 32'h0000_FFFF) begin
         m_def = wd[15:0];
      end else if (addr[31:16] == 16'd0 && addr[7:4] == 4'd0 && idx < DEPTH) begin
         case (w)
            0: m_key[idx][31:0]  = wd;
            1: m_key[idx][63:32] = wd;
            8: begin
               m_valid[idx] = wd[31];
               m_act[idx]   = wd[15:0];
            end
            9: m_cnt[idx] = '0;
            default: ;
         endcase
      end
   endfunction

   function automatic logic [31:0] ea(input int idx, input int w);
      return {16'h0000, 8'(idx), 4'h0, 4'(w)};
   endfunction

   // Per-cycle scoreboard; called with this cycle's inputs already applied.
   task automatic observe();
      res_t cur;
      res_t e;
      accepted = 1'b0;
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         cur = {action_hit, action_index, action};
         chk("p2k_ready", 64'(p2k_ready), 64'(!(action_valid && !action_ready)));
         if (prev_stall) begin
            chk("hold_valid", 64'(action_valid), 64'(1));
            chk("hold_result", 64'(cur), 64'(prev_res));
         end
         prev_stall = action_valid && !action_ready;
         prev_res   = cur;
         if (!p2k_ready) ready_low++;
         if (action_valid && action_ready) begin
            xfers++;
            last_res = cur;
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 64'(1), 64'(0));
            end else begin
               e        = exp_q.pop_front();
               last_lat = cyc - acc_cyc_q.pop_front();
               chk("action", 64'(action), 64'(e.act));
               chk("action_hit", 64'(action_hit), 64'(e.hit));
               chk("action_index", 64'(action_index), 64'(e.idx));
               if (e.hit && m_cnt[int'(e.idx)] != 32'hFFFF_FFFF) m_cnt[int'(e.idx)]++;
            end
         end
         if (p2k_valid && p2k_ready) begin
            accepted = 1'b1;
            exp_q.push_back(model_lookup(model_key()));
            acc_cyc_q.push_back(cyc);
         end
      end
   endtask

   task automatic step();
      #2;
      observe();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic req_key(input bit v, input bit m, input logic [63:0] k);
      p2k_valid    = v;
      mode         = m;
      p2k_ingress  = 8'($urandom);
      p2k_rloc_src = {$urandom, $urandom, m ? k : {$urandom, $urandom}};
      p2k_eid_dst  = {$urandom, $urandom, m ? {$urandom, $urandom} : k};
   endtask

   task automatic bus(input logic rdw, input logic [31:0] addr, input logic [31:0] wd,
                      input bit coinc, input int hold, output logic [31:0] rdata);
      localbus_cs_n  = 1'b1;
      localbus_ale   = 1'b1;
      localbus_data  = addr;
      step();
      localbus_ale   = 1'b0;
      localbus_cs_n  = 1'b0;
      localbus_rd_wr = rdw;
      localbus_data  = wd;
      step();
      chk("ack_exec", 64'(localbus_ack_n), 64'(1));
      if (coinc) action_ready = 1'b1;
      step();
      chk("ack_latency", 64'(localbus_ack_n), 64'(0));
      rdata = localbus_data_out;
      if (!rdw) model_write(addr, wd);
      for (int h = 0; h < hold; h++) begin
         step();
         chk("ack_wait", 64'(localbus_ack_n), 64'(1));
      end
      localbus_cs_n = 1'b1;
      step();
      chk("ack_release", 64'(localbus_ack_n), 64'(1));
      step();
   endtask

   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] dummy;
      bus(1'b0, addr, wd, 1'b0, 0, dummy);
   endtask

   task automatic bus_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] r;
      bus(1'b1, addr, 32'h0, 1'b0, 0, r);
      chk(tag, 64'(r), 64'(exp));
   endtask

   task automatic drain();
      p2k_valid    = 1'b0;
      action_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
      chk("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic lookup1(input bit m, input logic [63:0] k);
      action_ready = 1'b1;
      req_key(1'b1, m, k);
      step();
      chk("lookup_accepted", 64'(accepted), 64'(1));
      drain();
      chk("latency", 64'(last_lat), 64'(3));
   endtask

   initial begin
      reset          = 1'b0;
      p2k_valid      = 1'b0;
      p2k_ingress    = '0;
      p2k_rloc_src   = '0;
      p2k_eid_dst    = '0;
      mode           = 1'b0;
      action_ready   = 1'b1;
      localbus_cs_n  = 1'b1;
      localbus_rd_wr = 1'b1;
      localbus_data  = '0;
      localbus_ale   = 1'b0;
      model_reset();
      @(posedge clk);
      #1;

      // Reset state
      step();
      step();
      chk("rst_action_valid", 64'(action_valid), 64'(0));
      chk("rst_action", 64'(action), 64'(0));
      chk("rst_action_hit", 64'(action_hit), 64'(0));
      chk("rst_action_index", 64'(action_index), 64'(0));
      chk("rst_ack_n", 64'(localbus_ack_n), 64'(1));
      chk("rst_data_out", 64'(localbus_data_out), 64'(0));
      reset = 1'b1;
      step();
      chk("rst_p2k_ready", 64'(p2k_ready), 64'(1));

      // Read after reset; ack must not re-assert while cs_n stays low
      bus(1'b1, ea(0, 8), 32'h0, 1'b0, 3, rd);
      chk("r023_data", 64'(rd), 64'(0));

      // Basic hit on entry 3
      bus_wr(ea(3, 0), 32'hAAAA_5555);
      bus_wr(ea(3, 1), 32'h0000_0000);
      bus_wr(ea(3, 8), 32'h8000_0042);
      bus_rd("r018_keyword0", ea(3, 0), 32'hAAAA_5555);
      lookup1(1'b0, 64'h0000_0000_AAAA_5555);
      chk("r018_action", 64'(last_res.act), 64'(16'h0042));
      chk("r018_hit", 64'(last_res.hit), 64'(1));
      chk("r018_index", 64'(last_res.idx), 64'(3));

      // Duplicate keys resolve to the lowest valid index
      bus_wr(ea(2, 0), 32'h1234_5678);
      bus_wr(ea(2, 1), 32'h9ABC_DEF0);
      bus_wr(ea(2, 8), 32'h8000_0022);
      bus_wr(ea(5, 0), 32'h1234_5678);
      bus_wr(ea(5, 1), 32'h9ABC_DEF0);
      bus_wr(ea(5, 8), 32'h8000_0055);
      lookup1(1'b1, 64'h9ABC_DEF0_1234_5678);
      chk("r019_index_low", 64'(last_res.idx), 64'(2));
      bus_wr(ea(2, 8), 32'h0000_0022);
      lookup1(1'b0, 64'h9ABC_DEF0_1234_5678);
      chk("r019_index_next", 64'(last_res.idx), 64'(5));

      // Default action on miss
      bus_wr(32'h0000_FFFF, 32'h0000_0007);
      bus_rd("default_read", 32'h0000_FFFF, 32'h0000_0007);
      lookup1(1'b0, 64'h0BAD_0BAD_0BAD_0BAD);
      chk("r020_action", 64'(last_res.act), 64'(16'h0007));
      chk("r020_hit", 64'(last_res.hit), 64'(0));
      chk("r020_index", 64'(last_res.idx), 64'(0));

      // Out-of-range entry and unmapped word
      bus_wr(ea(16, 8), 32'h8000_1234);
      bus_rd("oor_entry", ea(16, 8), 32'h0);
      bus_rd("oor_no_alias", ea(0, 8), 32'h0);
      bus_wr(ea(3, 5), 32'hFFFF_FFFF);
      bus_rd("unmapped_word", ea(3, 5), 32'h0);

      // Four back-to-back requests with a 3-cycle consumer stall
      k21[0] = 64'h0000_0000_AAAA_5555;
      k21[1] = 64'h9ABC_DEF0_1234_5678;
      k21[2] = 64'h0123_4567_89AB_CDEF;
      k21[3] = 64'h0000_0000_AAAA_5555;
      sent      = 0;
      ready_low = 0;
      xfers     = 0;
      for (int i = 0; i < 15; i++) begin
         action_ready = !(i >= 4 && i < 7);
         if (sent < 4) req_key(1'b1, 1'b0, k21[sent]);
         else p2k_valid = 1'b0;
         step();
         if (accepted) sent++;
      end
      chk("r021_sent", 64'(sent), 64'(4));
      chk("r021_ready_low_cycles", 64'(ready_low), 64'(3));
      chk("r021_results", 64'(xfers), 64'(4));
      drain();

      // Hit counter: five hits, then a clear coinciding with a hit transfer
      bus_wr(ea(1, 0), 32'hCAFE_F00D);
      bus_wr(ea(1, 1), 32'h0BEE_F123);
      bus_wr(ea(1, 8), 32'h8000_0011);
      bus_wr(ea(1, 9), 32'h0);
      action_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         req_key(1'b1, 1'b1, 64'h0BEE_F123_CAFE_F00D);
         step();
      end
      drain();
      bus_rd("r022_count5", ea(1, 9), 32'd5);
      action_ready = 1'b0;
      req_key(1'b1, 1'b0, 64'h0BEE_F123_CAFE_F00D);
      step();
      p2k_valid = 1'b0;
      for (int i = 0; i < 8 && !action_valid; i++) step();
      chk("r022_result_pending", 64'(action_valid), 64'(1));
      bus(1'b0, ea(1, 9), 32'h0, 1'b1, 0, rd);
      drain();
      bus_rd("r022_clear_wins", ea(1, 9), 32'd0);

      // Randomized table and lookup stream
      for (int i = 0; i < 6; i++) pool[i] = {$urandom, $urandom};
      for (int i = 0; i < DEPTH; i++) begin
         logic [63:0] k;
         k = pool[$urandom_range(0, 5)];
         bus_wr(ea(i, 0), k[31:0]);
         bus_wr(ea(i, 1), k[63:32]);
         bus_wr(ea(i, 8), {($urandom_range(0, 3) != 0), 15'd0, 16'($urandom)});
      end
      bus_wr(32'h0000_FFFF, $urandom);
      p2k_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!p2k_valid || accepted) begin
            if ($urandom_range(0, 3) != 0) begin
               req_key(1'b1, 1'($urandom), ($urandom_range(0, 9) < 7) ?
                       pool[$urandom_range(0, 5)] : {$urandom, $urandom});
            end else begin
               p2k_valid = 1'b0;
            end
         end
         action_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drain();
      for (int i = 0; i < DEPTH; i++) bus_rd("rand_counter", ea(i, 9), m_cnt[i]);

      // Reset in the middle of a stall and a bus write
      action_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_key(1'b1, 1'b0, pool[i]);
         step();
      end
      p2k_valid = 1'b0;
      step();
      localbus_ale  = 1'b1;
      localbus_data = ea(7, 8);
      step();
      localbus_ale   = 1'b0;
      localbus_cs_n  = 1'b0;
      localbus_rd_wr = 1'b0;
      localbus_data  = 32'h8000_0011;
      step();
      reset = 1'b0;
      step();
      chk("midrst_valid", 64'(action_valid), 64'(0));
      chk("midrst_ack_n", 64'(localbus_ack_n), 64'(1));
      step();
      reset         = 1'b1;
      localbus_cs_n = 1'b1;
      action_ready  = 1'b1;
      exp_q.delete();
      acc_cyc_q.delete();
      model_reset();
      for (int i = 0; i < 8; i++) begin
         step();
         chk("post_rst_valid", 64'(action_valid), 64'(0));
         chk("post_rst_ack_n", 64'(localbus_ack_n), 64'(1));
      end
      bus_rd("post_rst_entry7", ea(7, 8), 32'h0);
      bus_rd("post_rst_entry3", ea(3, 8), 32'h0);
      bus_rd("post_rst_default", 32'h0000_FFFF, 32'h0);
      lookup1(1'b0, 64'h0000_0000_AAAA_5555);
      chk("post_rst_miss", 64'(last_res.hit), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
